// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its busy-bit scoreboard.
package regfile_pkg;

  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_AW    = $clog2(REG_DEPTH);

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;

  // True when an address names a real, modifiable register: inside the
  // array and not the hardwired zero register.
  function automatic logic reg_accessible(input int addr, input int depth, input bit zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy (pending-writeback) bit per register, with issue taking priority over
// a same-cycle writeback clear, and next-state lookup for both read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = REG_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          iss_en_i,
  input  logic [AW-1:0] iss_addr_i,
  input  logic [AW-1:0] rd_addr_a_i,
  input  logic [AW-1:0] rd_addr_b_i,
  output logic          busy_nxt_a_o,
  output logic          busy_nxt_b_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr_ok;
  logic             iss_ok;

  // Next busy state: writeback clears first, then issue sets, so issue wins.
  always_comb begin
    wr_ok  = wr_en_i && reg_accessible(int'(wr_addr_i), DEPTH, ZERO_REG != 0);
    iss_ok = iss_en_i && reg_accessible(int'(iss_addr_i), DEPTH, ZERO_REG != 0);
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_addr_i] = 1'b1;
    end
  end

  // Look up the post-update busy bits; absent or zero registers are never busy.
  always_comb begin
    busy_nxt_a_o = 1'b0;
    busy_nxt_b_o = 1'b0;
    if (reg_accessible(int'(rd_addr_a_i), DEPTH, ZERO_REG != 0)) begin
      busy_nxt_a_o = busy_d[rd_addr_a_i];
    end
    if (reg_accessible(int'(rd_addr_b_i), DEPTH, ZERO_REG != 0)) begin
      busy_nxt_b_o = busy_d[rd_addr_b_i];
    end
  end

  // Busy array state; reset clears every pending writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with two registered read ports, one forwarded
// write port and a per-register busy scoreboard for issue/writeback tracking.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = REG_WIDTH,
  parameter  int DEPTH    = REG_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             busy_a_q, busy_b_q;
  logic             busy_nxt_a, busy_nxt_b;
  logic             wr_ok;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (reset),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .iss_en_i     (iss_en),
    .iss_addr_i   (iss_addr),
    .rd_addr_a_i  (rd_addr_a),
    .rd_addr_b_i  (rd_addr_b),
    .busy_nxt_a_o (busy_nxt_a),
    .busy_nxt_b_o (busy_nxt_b)
  );

  // Read data as it will be after this cycle's write, so a same-cycle
  // writeback is forwarded; absent and zero registers read as 0.
  always_comb begin
    wr_ok       = wr_en && reg_accessible(int'(wr_addr), DEPTH, ZERO_REG != 0);
    rd_data_a_d = '0;
    rd_data_b_d = '0;
    if (reg_accessible(int'(rd_addr_a), DEPTH, ZERO_REG != 0)) begin
      rd_data_a_d = (wr_ok && (wr_addr == rd_addr_a)) ? wr_data : mem_q[rd_addr_a];
    end
    if (reg_accessible(int'(rd_addr_b), DEPTH, ZERO_REG != 0)) begin
      rd_data_b_d = (wr_ok && (wr_addr == rd_addr_b)) ? wr_data : mem_q[rd_addr_b];
    end
  end

  // Register storage; dropped writes never touch the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read-port output registers; they hold while rd_en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      busy_a_q    <= 1'b0;
      busy_b_q    <= 1'b0;
    end else if (rd_en) begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      busy_a_q    <= busy_nxt_a;
      busy_b_q    <= busy_nxt_b;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign busy_a    = busy_a_q;
  assign busy_b    = busy_b_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: one default instance (32x32, zero register)
// and one 20x16 instance without a zero register.
module tb_regfile_sb;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
    logic        chk;
    logic [15:0] tag;
  } expT;

  logic clk = 1'b0;
  logic reset;

  logic        rdEn0, wrEn0, issEn0;
  logic [4:0]  rdAddrA0, rdAddrB0, wrAddr0, issAddr0;
  logic [31:0] wrData0, rdDataA0, rdDataB0;
  logic        busyA0, busyB0;

  logic        rdEn1, wrEn1, issEn1;
  logic [4:0]  rdAddrA1, rdAddrB1, wrAddr1, issAddr1;
  logic [15:0] wrData1, rdDataA1, rdDataB1;
  logic        busyA1, busyB1;

  expT q0[$];
  expT q1[$];
  int  passCount = 0;
  int  checkCount = 0;
  int  vecNum = 0;

  always #5 clk = ~clk;

  regfile_sb dut0 (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rdEn0),
    .rd_addr_a (rdAddrA0),
    .rd_addr_b (rdAddrB0),
    .rd_data_a (rdDataA0),
    .rd_data_b (rdDataB0),
    .busy_a    (busyA0),
    .busy_b    (busyB0),
    .wr_en     (wrEn0),
    .wr_addr   (wrAddr0),
    .wr_data   (wrData0),
    .iss_en    (issEn0),
    .iss_addr  (issAddr0)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(20), .ZERO_REG(0)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rdEn1),
    .rd_addr_a (rdAddrA1),
    .rd_addr_b (rdAddrB1),
    .rd_data_a (rdDataA1),
    .rd_data_b (rdDataB1),
    .busy_a    (busyA1),
    .busy_b    (busyB1),
    .wr_en     (wrEn1),
    .wr_addr   (wrAddr1),
    .wr_data   (wrData1),
    .iss_en    (issEn1),
    .iss_addr  (issAddr1)
  );

  // Single comparison point shared by the monitor and the direct reset checks.
  task automatic checkOutput(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, tag, act, exp);
    end
  endtask

  task automatic idleAll();
    rdEn0 = 1'b0; wrEn0 = 1'b0; issEn0 = 1'b0;
    rdEn1 = 1'b0; wrEn1 = 1'b0; issEn1 = 1'b0;
  endtask

  // Drive one cycle on the selected instance and queue what its outputs
  // must show after the edge.
  task automatic applyStimulus(input int sel, input logic rdEn, input int addrA, input int addrB,
                               input logic wrEn, input int wrAddr, input logic [31:0] wrData,
                               input logic issEn, input int issAddr, input logic chk,
                               input logic [31:0] expA, input logic [31:0] expB,
                               input logic expBa, input logic expBb);
    expT e;
    vecNum++;
    idleAll();
    if (sel == 0) begin
      rdEn0 = rdEn; rdAddrA0 = addrA[4:0]; rdAddrB0 = addrB[4:0];
      wrEn0 = wrEn; wrAddr0 = wrAddr[4:0]; wrData0 = wrData;
      issEn0 = issEn; issAddr0 = issAddr[4:0];
    end else begin
      rdEn1 = rdEn; rdAddrA1 = addrA[4:0]; rdAddrB1 = addrB[4:0];
      wrEn1 = wrEn; wrAddr1 = wrAddr[4:0]; wrData1 = wrData[15:0];
      issEn1 = issEn; issAddr1 = issAddr[4:0];
    end
    e = '{a: expA, b: expB, ba: expBa, bb: expBb, chk: chk, tag: vecNum[15:0]};
    @(posedge clk);
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
    #1;
  endtask

  // Monitor: one queued expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    expT e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      if (e.chk) begin
        checkOutput("dut0 rd_data_a", int'(e.tag), rdDataA0, e.a);
        checkOutput("dut0 rd_data_b", int'(e.tag), rdDataB0, e.b);
        checkOutput("dut0 busy_a", int'(e.tag), {31'b0, busyA0}, {31'b0, e.ba});
        checkOutput("dut0 busy_b", int'(e.tag), {31'b0, busyB0}, {31'b0, e.bb});
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      if (e.chk) begin
        checkOutput("dut1 rd_data_a", int'(e.tag), {16'b0, rdDataA1}, e.a);
        checkOutput("dut1 rd_data_b", int'(e.tag), {16'b0, rdDataB1}, e.b);
        checkOutput("dut1 busy_a", int'(e.tag), {31'b0, busyA1}, {31'b0, e.ba});
        checkOutput("dut1 busy_b", int'(e.tag), {31'b0, busyB1}, {31'b0, e.bb});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idleAll();
    rdAddrA0 = '0; rdAddrB0 = '0; wrAddr0 = '0; wrData0 = '0; issAddr0 = '0;
    rdAddrA1 = '0; rdAddrB1 = '0; wrAddr1 = '0; wrData1 = '0; issAddr1 = '0;
    #2;
    checkOutput("reset rd_data_a", 0, rdDataA0, 32'h0);
    checkOutput("reset busy_a", 0, {31'b0, busyA0}, 32'h0);
    checkOutput("reset dut1 rd_data_b", 0, {16'b0, rdDataB1}, 32'h0);
    #10 reset = 1'b1;

    // Fresh array: every address reads zero and idle.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1, i, 31 - i, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0);
    end

    // Forwarding, issue/writeback busy tracking, issue-wins collision.
    applyStimulus(0, 1, 3, 3, 1, 3, 32'h1234, 0, 0, 1, 32'h1234, 32'h1234, 0, 0);
    applyStimulus(0, 1, 7, 3, 0, 0, 0, 1, 7, 1, 32'h0, 32'h1234, 1, 0);
    applyStimulus(0, 1, 7, 7, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 1);
    applyStimulus(0, 1, 7, 3, 1, 7, 32'h55, 0, 0, 1, 32'h55, 32'h1234, 0, 0);
    applyStimulus(0, 1, 7, 7, 1, 7, 32'h66, 1, 7, 1, 32'h66, 32'h66, 1, 1);
    applyStimulus(0, 1, 7, 3, 0, 0, 0, 0, 0, 1, 32'h66, 32'h1234, 1, 0);

    // Zero register ignores write and issue.
    applyStimulus(0, 1, 0, 0, 1, 0, 32'hFFFF, 1, 0, 1, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 32'h0, 32'h66, 0, 1);

    // Outputs hold while rd_en is low, then pick up the new value.
    applyStimulus(0, 1, 2, 2, 1, 2, 32'h10, 0, 0, 1, 32'h10, 32'h10, 0, 0);
    applyStimulus(0, 0, 2, 2, 1, 2, 32'h20, 0, 0, 1, 32'h10, 32'h10, 0, 0);
    applyStimulus(0, 0, 2, 2, 0, 0, 0, 0, 0, 1, 32'h10, 32'h10, 0, 0);
    applyStimulus(0, 1, 2, 2, 0, 0, 0, 0, 0, 1, 32'h20, 32'h20, 0, 0);

    // Mid-run reset wipes data, busy bits and a write/issue pending across it.
    applyStimulus(0, 1, 5, 5, 1, 5, 32'hDEAD, 0, 0, 1, 32'hDEAD, 32'hDEAD, 0, 0);
    @(negedge clk); #1;
    rdEn0 = 1'b1; rdAddrA0 = 5'd6; rdAddrB0 = 5'd7;
    wrEn0 = 1'b1; wrAddr0 = 5'd6; wrData0 = 32'hBEEF;
    issEn0 = 1'b1; issAddr0 = 5'd6;
    reset = 1'b0;
    #1;
    checkOutput("async reset rd_data_a", 0, rdDataA0, 32'h0);
    checkOutput("async reset rd_data_b", 0, rdDataB0, 32'h0);
    checkOutput("async reset busy_b", 0, {31'b0, busyB0}, 32'h0);
    @(posedge clk); #1;
    checkOutput("held reset rd_data_a", 0, rdDataA0, 32'h0);
    @(negedge clk); #1;
    idleAll();
    reset = 1'b1;
    applyStimulus(0, 1, 5, 6, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 1, 7, 3, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 0);

    // 20x16 instance without a zero register.
    applyStimulus(1, 1, 0, 0, 1, 0, 32'hFFFF, 1, 0, 1, 32'hFFFF, 32'hFFFF, 1, 1);
    applyStimulus(1, 1, 19, 0, 1, 19, 32'hAAAA, 0, 0, 1, 32'hAAAA, 32'hFFFF, 0, 1);
    applyStimulus(1, 1, 25, 25, 1, 25, 32'hBEEF, 1, 25, 1, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, i, 19, 0, 0, 0, 0, 0, 1,
                    (i == 0) ? 32'hFFFF : ((i == 19) ? 32'hAAAA : 32'h0),
                    32'hAAAA, (i == 0), 0);
    end
    applyStimulus(1, 1, 19, 19, 0, 0, 0, 0, 0, 1, 32'hAAAA, 32'hAAAA, 0, 0);

    idleAll();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("scoreboard drained", 0, q0.size() + q1.size(), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
